// File: rtl/ws2812_frame_scheduler.sv
// Ping-pong pixel store and frame sequencer feeding a WS2812 serializer.
// The host fills the back bank and commits; banks swap on the next idle frame tick.
module ws2812_frame_scheduler #(
  parameter int MAX_LEDS    = 256,
  parameter int ADDR_W      = 8,
  parameter int FRAME_TICKS = 1666667
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_wr_en,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [23:0]       host_wr_data,
  input  logic [15:0]       host_num_leds,
  input  logic              host_commit,
  output logic              commit_pending,
  input  logic              ser_read_en,
  output logic [23:0]       ser_rgb_data,
  output logic              ser_data_dv,
  output logic [15:0]       ser_num_leds,
  output logic [15:0]       ser_data_depth,
  output logic              ser_write_config,
  output logic              frame_start,
  output logic [15:0]       frame_count,
  output logic              frame_overrun
);
  localparam int TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int PTR_W  = (MAX_LEDS > 1) ? $clog2(MAX_LEDS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(FRAME_TICKS - 1);
  localparam logic [15:0]       MAX_LEDS_16 = 16'(MAX_LEDS);

  typedef enum logic [1:0] {IDLE, CONFIG, STREAM} state_t;

  state_t            state_reg, state_next;
  logic [TICK_W-1:0] tick_cnt_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic              front_sel_reg;
  logic              commit_pending_reg;
  logic              rd_en_prev_reg;
  logic [15:0]       active_leds_reg;
  logic [15:0]       pending_leds_reg;
  logic [15:0]       ser_num_leds_reg;
  logic [15:0]       frame_count_reg;
  logic              dv_reg;
  logic              rd_zero_reg;
  logic              overrun_reg;
  logic [23:0]       rd_data_reg;
  logic [23:0]       mem [2][MAX_LEDS];

  logic        tick, req, rd_fire, wr_ok, last_pixel, swap;
  logic [15:0] launch_leds, clamped_leds;

  assign tick         = (tick_cnt_reg == TICK_LAST);
  assign req          = ser_read_en & ~rd_en_prev_reg;
  assign rd_fire      = req && (state_reg == STREAM);
  assign wr_ok        = host_wr_en && (int'(host_wr_addr) < MAX_LEDS);
  assign last_pixel   = (16'(rd_ptr_reg) == active_leds_reg - 16'd1);
  assign swap         = (state_reg == IDLE) && tick && commit_pending_reg;
  assign launch_leds  = commit_pending_reg ? pending_leds_reg : active_leds_reg;
  assign clamped_leds = (host_num_leds > MAX_LEDS_16) ? MAX_LEDS_16 : host_num_leds;

  // Both banks share one array; the read port only ever touches the front bank.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[~front_sel_reg][host_wr_addr[PTR_W-1:0]] <= host_wr_data;
    end
    if (rd_fire) begin
      rd_data_reg <= mem[front_sel_reg][rd_ptr_reg];
    end
  end

  always_comb begin
    state_next       = state_reg;
    ser_write_config = 1'b0;
    frame_start      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (tick && (launch_leds != 16'd0)) state_next = CONFIG;
      end
      CONFIG: begin
        ser_write_config = 1'b1;
        frame_start      = 1'b1;
        state_next       = STREAM;
      end
      STREAM: begin
        if (rd_fire && last_pixel) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= IDLE;
      tick_cnt_reg       <= '0;
      rd_ptr_reg         <= '0;
      front_sel_reg      <= 1'b0;
      commit_pending_reg <= 1'b0;
      rd_en_prev_reg     <= 1'b0;
      active_leds_reg    <= '0;
      pending_leds_reg   <= '0;
      ser_num_leds_reg   <= '0;
      frame_count_reg    <= '0;
      dv_reg             <= 1'b0;
      rd_zero_reg        <= 1'b1;
      overrun_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      tick_cnt_reg   <= tick ? '0 : tick_cnt_reg + TICK_W'(1);
      rd_en_prev_reg <= ser_read_en;
      dv_reg         <= req;
      if (req) rd_zero_reg <= (state_reg != STREAM);
      if (rd_fire) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);

      if (swap) begin
        front_sel_reg   <= ~front_sel_reg;
        active_leds_reg <= pending_leds_reg;
      end

      // Count and LED number are loaded on entry so they are valid during the config strobe.
      if ((state_reg == IDLE) && (state_next == CONFIG)) begin
        ser_num_leds_reg <= launch_leds;
        frame_count_reg  <= frame_count_reg + 16'd1;
        rd_ptr_reg       <= '0;
      end

      // A commit landing on the swap tick wins and stays queued for the following tick.
      if (host_commit) begin
        pending_leds_reg   <= clamped_leds;
        commit_pending_reg <= 1'b1;
      end else if (swap) begin
        commit_pending_reg <= 1'b0;
      end

      if (tick && (state_reg != IDLE)) overrun_reg <= 1'b1;
    end
  end

  assign commit_pending = commit_pending_reg;
  assign ser_rgb_data   = rd_zero_reg ? 24'h000000 : rd_data_reg;
  assign ser_data_dv    = dv_reg;
  assign ser_num_leds   = ser_num_leds_reg;
  assign ser_data_depth = ser_num_leds_reg;
  assign frame_count    = frame_count_reg;
  assign frame_overrun  = overrun_reg;
endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Randomized scoreboard bench for ws2812_frame_scheduler against a frame-level reference model.
module tb_ws2812_frame_scheduler;
  localparam int MAXL = 256;
  localparam int AW   = 9;
  localparam int FT   = 100;
  localparam int M_IDLE   = 0;
  localparam int M_CONFIG = 1;
  localparam int M_STREAM = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          host_wr_en = 1'b0;
  logic [AW-1:0] host_wr_addr = '0;
  logic [23:0]   host_wr_data = '0;
  logic [15:0]   host_num_leds = '0;
  logic          host_commit = 1'b0;
  logic          ser_read_en = 1'b0;
  logic          commit_pending;
  logic [23:0]   ser_rgb_data;
  logic          ser_data_dv;
  logic [15:0]   ser_num_leds;
  logic [15:0]   ser_data_depth;
  logic          ser_write_config;
  logic          frame_start;
  logic [15:0]   frame_count;
  logic          frame_overrun;

  ws2812_frame_scheduler #(.MAX_LEDS(MAXL), .ADDR_W(AW), .FRAME_TICKS(FT)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_num_leds(host_num_leds), .host_commit(host_commit), .commit_pending(commit_pending),
    .ser_read_en(ser_read_en), .ser_rgb_data(ser_rgb_data), .ser_data_dv(ser_data_dv),
    .ser_num_leds(ser_num_leds), .ser_data_depth(ser_data_depth),
    .ser_write_config(ser_write_config), .frame_start(frame_start),
    .frame_count(frame_count), .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit pend;
    bit ovr;
    bit dv;
    bit cfg;
    int fc;
  } status_t;

  status_t     sq[$];
  logic [23:0] pixq[$];
  int          cfgq[$];

  // Reference model: frame-level view of the scheduler
  int          m_tcnt, m_mode, m_ptr, m_active, m_pend_leds, m_fc;
  bit          m_prev, m_pending, m_front, m_ovr;
  logic [23:0] m_bank [2][MAXL];

  task automatic model_reset();
    m_tcnt = 0; m_mode = M_IDLE; m_ptr = 0; m_active = 0; m_pend_leds = 0; m_fc = 0;
    m_prev = 0; m_pending = 0; m_front = 0; m_ovr = 0;
  endtask

  task automatic step(bit wr, int addr, logic [23:0] data, bit cm, int num, bit rd);
    bit tick, req;
    int old_mode;
    status_t st;
    host_wr_en = wr; host_wr_addr = AW'(addr); host_wr_data = data;
    host_commit = cm; host_num_leds = 16'(num); ser_read_en = rd;
    tick = (m_tcnt == FT - 1);
    req = rd && !m_prev;
    old_mode = m_mode;
    if (req) begin
      if (old_mode == M_STREAM) begin
        pixq.push_back(m_bank[m_front][m_ptr]);
        m_ptr++;
        if (m_ptr == m_active) m_mode = M_IDLE;
      end else begin
        pixq.push_back(24'h000000);
      end
    end
    if (wr && addr < MAXL) m_bank[!m_front][addr] = data;
    if (old_mode == M_CONFIG) begin
      m_mode = M_STREAM;
      m_ptr = 0;
    end
    if (tick) begin
      if (old_mode != M_IDLE) m_ovr = 1;
      else begin
        if (m_pending) begin
          m_front = !m_front;
          m_active = m_pend_leds;
          m_pending = 0;
        end
        if (m_active != 0) begin
          m_mode = M_CONFIG;
          m_fc = (m_fc + 1) % 65536;
          cfgq.push_back(m_active);
        end
      end
    end
    if (cm) begin
      m_pend_leds = (num > MAXL) ? MAXL : num;
      m_pending = 1;
    end
    m_tcnt = tick ? 0 : m_tcnt + 1;
    m_prev = rd;
    st.pend = m_pending; st.ovr = m_ovr; st.dv = req;
    st.cfg = (m_mode == M_CONFIG); st.fc = m_fc;
    sq.push_back(st);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 24'h0, 0, 0, 0);
  endtask

  task automatic wr(int a, logic [23:0] d);
    step(1, a, d, 0, 0, 0);
  endtask

  task automatic commit(int n);
    step(0, 0, 24'h0, 1, n, 0);
  endtask

  task automatic request();
    step(0, 0, 24'h0, 0, 0, 1);
    repeat ($urandom_range(0, 2)) step(0, 0, 24'h0, 0, 0, 1);
    step(0, 0, 24'h0, 0, 0, 0);
    repeat ($urandom_range(0, 2)) step(0, 0, 24'h0, 0, 0, 0);
  endtask

  task automatic request_fast();
    step(0, 0, 24'h0, 0, 0, 1);
    step(0, 0, 24'h0, 0, 0, 0);
  endtask

  task automatic run_to_tick();
    while (m_tcnt != FT - 1) idle(1);
    idle(1);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_commit_pending"}, commit_pending, 0);
    chk({tag, "_rgb"}, ser_rgb_data, 0);
    chk({tag, "_dv"}, ser_data_dv, 0);
    chk({tag, "_num_leds"}, ser_num_leds, 0);
    chk({tag, "_depth"}, ser_data_depth, 0);
    chk({tag, "_write_config"}, ser_write_config, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_frame_count"}, frame_count, 0);
    chk({tag, "_overrun"}, frame_overrun, 0);
  endtask

  // Monitor: one status record per clock, payload queues popped when the DUT presents data
  initial begin
    status_t st;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n) begin
        if (sq.size() == 0) begin
          if (ser_data_dv || ser_write_config) begin
            total++; bad++;
            $display("FAIL unexpected_output: dv=%0b cfg=%0b with nothing expected", ser_data_dv, ser_write_config);
          end
        end else begin
          st = sq.pop_front();
          chk("commit_pending", commit_pending, st.pend);
          chk("frame_overrun", frame_overrun, st.ovr);
          chk("data_dv", ser_data_dv, st.dv);
          chk("write_config", ser_write_config, st.cfg);
          chk("frame_start", frame_start, st.cfg);
          chk("frame_count", frame_count, st.fc);
          if (ser_data_dv) begin
            if (pixq.size() == 0) begin
              total++; bad++;
              $display("FAIL pixel: got %06h expected no pixel", ser_rgb_data);
            end else chk("pixel", ser_rgb_data, pixq.pop_front());
          end
          if (ser_write_config) begin
            if (cfgq.size() == 0) begin
              total++; bad++;
              $display("FAIL config: got num_leds=%0d expected no config", ser_num_leds);
            end else begin
              int nl;
              nl = cfgq.pop_front();
              chk("ser_num_leds", ser_num_leds, nl);
              chk("ser_data_depth", ser_data_depth, nl);
            end
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #20 chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Preload both banks so every readable location is known
    for (int i = 0; i < MAXL; i++) wr(i, 24'($urandom()));
    commit(0);
    run_to_tick();
    for (int i = 0; i < MAXL; i++) wr(i, 24'($urandom()));

    // Basic four-pixel frame, extra request, relaunch
    wr(0, 24'h0000FF); wr(1, 24'h00FF00); wr(2, 24'hFF0000); wr(3, 24'hFFFFFF);
    commit(4);
    run_to_tick();
    repeat (4) request();
    request();
    run_to_tick();
    repeat (4) request();

    // Oversized count is clamped; out-of-range write is dropped; slow stream overruns
    wr(300, 24'hABCDEF);
    commit(1000);
    run_to_tick();
    for (int i = 0; i < MAXL; i++) begin
      request_fast();
      if (i == 40) idle(FT);
      if (i == 100) commit(0);
    end
    run_to_tick();

    // Commit coincident with a tick while another commit is pending
    wr(0, 24'($urandom())); wr(1, 24'($urandom())); wr(2, 24'($urandom()));
    commit(3);
    while (m_tcnt != FT - 1) idle(1);
    commit(5);
    repeat (3) request();
    run_to_tick();
    repeat (5) request();
    commit(0);
    run_to_tick();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 3) == 0), int'($urandom_range(0, 259)), 24'($urandom()),
           ($urandom_range(0, 60) == 0), int'($urandom_range(0, 6)), ($urandom_range(0, 1) == 1));
    end
    commit(0);
    for (int k = 0; k < 2000 && (m_pending || m_mode != M_IDLE); k++) begin
      step(0, 0, 24'h0, 0, 0, ((k % 2) == 1));
    end

    // Asynchronous reset in the middle of a stream
    for (int i = 0; i < 4; i++) wr(i, 24'($urandom()));
    commit(4);
    run_to_tick();
    idle(1);
    request();
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    sq.delete(); pixq.delete(); cfgq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(250);
    commit(2);
    run_to_tick();
    repeat (2) request();
    idle(3);

    chk("pixel_queue_drained", pixq.size(), 0);
    chk("config_queue_drained", cfgq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
